// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Pipeline control for the 16-bit five-stage core (IF, ID, EX, MEM, WB).
//   It tracks the destination registers of the instructions in EX and MEM.
//   From these it produces the PC and IF/ID enables, the IF/ID flush and
//   ID/EX bubble controls, and registered forwarding selects for the EX
//   operand muxes. It also keeps saturating load-use stall and branch flush
//   counters.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_*                  register fields and flags of the instruction in ID
//   ex_branch_taken       branch/jump resolved taken in EX this cycle
//   mem_ready             0 freezes the whole pipeline
//   pc_write, ifid_write  PC and IF/ID register enables
//   ifid_flush            clear IF/ID to NOP
//   idex_bubble           load NOP into ID/EX
//   fwd_a, fwd_b          EX operand selects: 00 regfile, 01 MEM, 10 WB
//   stall_count           load-use stall cycles (saturating)
//   flush_count           taken-branch flushes (saturating)
module hazard_forward_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reads_rs,
  input  logic             id_reads_rt,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // A producer in WB is not tracked: the WB-stage forward is selected one
  // edge earlier from the MEM-stage match, and same-cycle WB-to-ID reads are
  // covered by the write-through register file.
  logic             ex_v_q, ex_v_d;
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_ld_q, ex_ld_d;
  logic             mem_v_q, mem_v_d;
  logic [REG_W-1:0] mem_rd_q, mem_rd_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, load_use;

  // Register 0 is hardwired zero, so it never matches.
  function automatic logic src_match(input logic             rd_en,
                                     input logic [REG_W-1:0] src,
                                     input logic             stg_v,
                                     input logic [REG_W-1:0] stg_rd);
    return rd_en && (src != '0) && stg_v && (stg_rd == src);
  endfunction

  // Youngest producer (EX) wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)  return 2'b01;
    if (mem_hit) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign ex_rs_hit  = src_match(id_reads_rs, id_rs, ex_v_q,  ex_rd_q);
  assign ex_rt_hit  = src_match(id_reads_rt, id_rt, ex_v_q,  ex_rd_q);
  assign mem_rs_hit = src_match(id_reads_rs, id_rs, mem_v_q, mem_rd_q);
  assign mem_rt_hit = src_match(id_reads_rt, id_rt, mem_v_q, mem_rd_q);
  assign load_use   = id_valid & ex_v_q & ex_ld_q & (ex_rs_hit | ex_rt_hit);

  // Freeze beats branch, branch beats load-use.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (mem_ready) begin
      if (ex_branch_taken) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        idex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    end
  end

  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rd_d  = ex_rd_q;
    ex_ld_d  = ex_ld_q;
    mem_v_d  = mem_v_q;
    mem_rd_d = mem_rd_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    stall_d  = stall_q;
    flush_d  = flush_q;
    if (mem_ready) begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      if (idex_bubble) begin
        ex_v_d  = 1'b0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        ex_v_d  = id_valid & id_writes_rd & (id_rd != '0);
        ex_rd_d = id_rd;
        ex_ld_d = id_is_load;
        fwd_a_d = fwd_sel(ex_rs_hit, mem_rs_hit);
        fwd_b_d = fwd_sel(ex_rt_hit, mem_rt_hit);
      end
      if (load_use && !ex_branch_taken) stall_d = sat_inc(stall_q);
      if (ex_branch_taken)              flush_d = sat_inc(flush_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= '0;
      ex_ld_q  <= 1'b0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= '0;
      fwd_a_q  <= 2'b00;
      fwd_b_q  <= 2'b00;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      ex_ld_q  <= ex_ld_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule
